// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between four byte-stream requesters.
// Round-robin arbitration picks an owner, which keeps the transmitter until its packet
// ends (req_last), it has sent MAX_BURST bytes, or it sits idle for STALL_TIMEOUT cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req_valid  in   [3:0] per-requester byte valid
//   req_data   in   [4*DATA_W-1:0] packed bytes, requester i at slice i
//   req_last   in   [3:0] per-requester end-of-packet, qualified by req_valid
//   req_ready  out  [3:0] per-requester byte accept (combinational)
//   grant      out  [3:0] one-hot owner, zero when unowned
//   grant_id   out  [1:0] binary owner index, zero when unowned
//   tx_start   out  one-cycle start pulse to the transmitter
//   tx_data    out  [DATA_W-1:0] byte for the transmitter
//   tx_busy    in   transmitter busy, blocks accepts
//   tx_done    in   transmitter finished a frame
module uart_tx_arbiter #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req_valid,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic [3:0]            req_last,
  output logic [3:0]            req_ready,
  output logic [3:0]            grant,
  output logic [1:0]            grant_id,
  output logic                  tx_start,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned StallW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, START, WAIT} state_t;

  state_t              r_state, w_state_d;
  logic [1:0]          r_ptr, w_ptr_d;
  logic [3:0]          r_grant, w_grant_d;
  logic [1:0]          r_grant_id, w_grant_id_d;
  logic                r_tx_start, w_tx_start_d;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_d;
  logic [BurstW-1:0]   r_burst_cnt, w_burst_cnt_d;
  logic [StallW-1:0]   r_stall_cnt, w_stall_cnt_d;
  logic                r_last, w_last_d;

  logic                w_arb_hit;
  logic [1:0]          w_arb_id;
  logic [DATA_W-1:0]   w_owner_data;
  logic                w_accept;
  logic                w_release;

  // Round-robin search starting at r_ptr; the 2-bit sum wraps mod 4.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_id  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!w_arb_hit && req_valid[r_ptr + 2'(i)]) begin
        w_arb_hit = 1'b1;
        w_arb_id  = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_owner_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_grant_id == 2'(i)) w_owner_data = req_data[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    req_ready = 4'b0000;
    if (r_state == ISSUE) req_ready[r_grant_id] = req_valid[r_grant_id] & ~tx_busy;
  end

  assign w_accept = (r_state == ISSUE) && req_valid[r_grant_id] && !tx_busy;

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_grant_d     = r_grant;
    w_grant_id_d  = r_grant_id;
    w_tx_start_d  = 1'b0;
    w_tx_data_d   = r_tx_data;
    w_burst_cnt_d = r_burst_cnt;
    w_stall_cnt_d = r_stall_cnt;
    w_last_d      = r_last;
    w_release     = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_grant_d    = 4'b0000;
        w_grant_id_d = 2'd0;
        if (w_arb_hit) begin
          w_grant_d     = 4'b0001 << w_arb_id;
          w_grant_id_d  = w_arb_id;
          w_burst_cnt_d = '0;
          w_stall_cnt_d = '0;
          w_state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (w_accept) begin
          w_tx_data_d   = w_owner_data;
          w_last_d      = req_last[r_grant_id];
          w_burst_cnt_d = r_burst_cnt + BurstW'(1);
          w_stall_cnt_d = '0;
          w_tx_start_d  = 1'b1;  // registered, so the pulse lands in START
          w_state_d     = START;
        end else begin
          // Busy transmitter counts as owner idle too, so a stuck tx_busy still times out.
          w_stall_cnt_d = r_stall_cnt + StallW'(1);
          if (w_stall_cnt_d == StallW'(STALL_TIMEOUT)) w_release = 1'b1;
        end
      end
      START: begin
        w_state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (r_last || (r_burst_cnt == BurstW'(MAX_BURST))) w_release = 1'b1;
          else w_state_d = ISSUE;
        end
      end
      default: w_state_d = IDLE;
    endcase

    if (w_release) begin
      w_grant_d    = 4'b0000;
      w_grant_id_d = 2'd0;
      w_ptr_d      = r_grant_id + 2'd1;
      w_state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_grant     <= 4'b0000;
      r_grant_id  <= 2'd0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_burst_cnt <= '0;
      r_stall_cnt <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_grant     <= w_grant_d;
      r_grant_id  <= w_grant_id_d;
      r_tx_start  <= w_tx_start_d;
      r_tx_data   <= w_tx_data_d;
      r_burst_cnt <= w_burst_cnt_d;
      r_stall_cnt <= w_stall_cnt_d;
      r_last      <= w_last_d;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, byte width on requester and transmitter sides.
REQ-002 Parameter: MAX_BURST, 16, max bytes per grant before forced release (>=1).
REQ-003 Parameter: STALL_TIMEOUT, 64, owner-idle cycles before forced release (>=1).
REQ-004 Port: clk  input  1  system clock, all logic on rising edge.
REQ-005 Port: reset  input  1  reset, asynchronous, active-high.
REQ-006 Port: req_valid  input  4  per-requester byte-valid; bit i = requester i.
REQ-007 Port: req_data  input  4*DATA_W  packed bytes; requester i at [DATA_W*i+DATA_W-1 : DATA_W*i].
REQ-008 Port: req_last  input  4  per-requester end-of-packet flag, qualified by req_valid.
REQ-009 Port: req_ready  output  4  per-requester byte accept; combinational.
REQ-010 Port: grant  output  4  one-hot current owner, zero when unowned; registered.
REQ-011 Port: grant_id  output  2  binary index of owner, 0 when unowned; registered.
REQ-012 Port: tx_start  output  1  one-cycle pulse to UART transmitter; registered.
REQ-013 Port: tx_data  output  DATA_W  byte for transmitter, stable from tx_start until next accept; registered.
REQ-014 Port: tx_busy  input  1  transmitter busy; blocks new accepts.
REQ-015 Port: tx_done  input  1  one-cycle pulse, transmitter finished frame.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, START, WAIT.
REQ-017 IDLE: if any req_valid, winner = first set bit searching ptr, ptr+1, ... mod 4; grant/grant_id loaded, burst_cnt cleared, stall_cnt cleared, go ISSUE next cycle (grant latency 1 cycle).
REQ-018 IDLE with req_valid all zero: stay IDLE, grant = 0.
REQ-019 ISSUE: req_ready[owner] = req_valid[owner] & ~tx_busy; all other req_ready bits = 0 in every state.
REQ-020 ISSUE accept (req_valid[owner] & req_ready[owner]): tx_data <= owner byte, last_r <= req_last[owner], burst_cnt += 1, stall_cnt cleared, go START.
REQ-021 ISSUE without accept: stall_cnt += 1; when stall_cnt reaches STALL_TIMEOUT, release (REQ-024) without sending.
REQ-022 START: tx_start = 1 for exactly this one cycle, go WAIT.
REQ-023 WAIT: hold until tx_done; tx_done outside WAIT SHALL be ignored; on tx_done, release if last_r = 1 or burst_cnt = MAX_BURST, else return to ISSUE with same owner.
REQ-024 Release: grant <= 0, grant_id <= 0, ptr <= (owner + 1) mod 4, go IDLE; re-arbitration earliest the following cycle.
REQ-025 Non-owner req_valid changes while owned SHALL have no effect; owner drop of req_valid in WAIT/START has no effect.
REQ-026 burst_cnt width SHALL hold MAX_BURST without wrap; stall_cnt width SHALL hold STALL_TIMEOUT without wrap.
REQ-027 ptr wrap-around: owner 3 release sets ptr = 0.
REQ-028 tx_busy high on ISSUE entry: no accept, stall_cnt still increments (timeout applies).

Reset
REQ-029 reset assertion SHALL immediately force: state IDLE, ptr 0, grant 0, grant_id 0, tx_start 0, tx_data 0, burst_cnt 0, stall_cnt 0, last_r 0; req_ready therefore 0.
REQ-030 reset mid-frame SHALL abandon the byte in flight; first arbitration after deassertion starts at requester 0.

Verification
REQ-031 Requester 1 sends 0xA5 with last=1, others idle -> grant=4'b0010 one cycle later, req_ready[1] one cycle, tx_start one cycle with tx_data=0xA5, after tx_done grant=0, next priority requester 2.
REQ-032 After reset all four request single bytes (last=1) 0x10,0x11,0x12,0x13 -> transmit order 0x10,0x11,0x12,0x13, grant_id 0,1,2,3.
REQ-033 Requester 2 streams 20 bytes, last=0, requester 3 also valid -> 16 bytes sent for 2, release, requester 3 granted, then 2 regains for remaining 4.
REQ-034 Requester 0 granted, drops req_valid -> release exactly 64 cycles after ISSUE entry, no tx_start, grant=0.
REQ-035 tx_busy held high 10 cycles in ISSUE -> req_ready[owner]=0 for those cycles, accept on first cycle busy low.
REQ-036 reset pulsed during WAIT of requester 2 -> all outputs 0 immediately; after deassertion with requesters 0 and 2 valid, requester 0 granted first.
